test_mode_controller: RTL
=========================

TEST_MODE_CONTROLLER -- requirements
Module: test_mode_controller

Interface
REQ-001 Parameter NUM_ENGINES, default 3: number of test engines; engine 0 is normal ACQ, engines 1..NUM_ENGINES-1 are sweep-type (sweep ACQ, S-curve, ...).
REQ-002 Parameter DATA_W, default 16: USB FIFO data width.
REQ-003 Parameter DAC_W, default 10, and NUM_DAC, default 3: width and count of Microroc threshold DACs.
REQ-004 Parameter TIMEOUT_W, default 24: width of the config-done watchdog counter.
REQ-005 Clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-006 ModeSelect  in  clog2(NUM_ENGINES)  requested engine; StartStop  in  1  USB start(1)/stop(0) level.
REQ-007 EngineStart  out  NUM_ENGINES  one-hot start level; EngineDone  in  NUM_ENGINES  done pulses.
REQ-008 EngineDac  in  NUM_ENGINES*DAC_W  engine DAC values; EngineScLoad  in  NUM_ENGINES  SC load pulses.
REQ-009 UsbDac  in  NUM_DAC*DAC_W; DacSelect  in  clog2(NUM_DAC); OutDac  out  NUM_DAC*DAC_W.
REQ-010 UsbScLoad  in  1; OutScLoad  out  1; MicrorocConfigDone  in  1.
REQ-011 EngineData  in  NUM_ENGINES*DATA_W; EngineData_en  in  NUM_ENGINES; UsbDataFifoFull  in  1.
REQ-012 OutUsbExtFifoData  out  DATA_W; OutUsbExtFifoData_en  out  1; OutUsbStartStop  out  1.
REQ-013 DataTransmitDone  in  1; SweepTestDone  out  1; ConfigTimeout  out  1; Busy  out  1; ActiveMode  out  clog2(NUM_ENGINES); DropCount  out  16.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; Busy = 1 in every state except IDLE.
REQ-015 IDLE: on StartStop 0->1 edge with ModeSelect < NUM_ENGINES, latch ModeSelect into ActiveMode and enter RUN next cycle; out-of-range ModeSelect ignored, FSM stays IDLE.
REQ-016 ModeSelect changes outside IDLE are ignored; ActiveMode holds until return to IDLE.
REQ-017 RUN: EngineStart[ActiveMode] = 1, all other bits 0; OutUsbStartStop = 1.
REQ-018 RUN -> DRAIN on EngineDone[ActiveMode] or StartStop 1->0 edge; both in the same cycle is a single transition.
REQ-019 DRAIN: EngineStart all 0, OutUsbStartStop held 1 until DataTransmitDone = 1, then enter DONE.
REQ-020 DONE: SweepTestDone = 1 for exactly one cycle, OutUsbStartStop = 0, next state IDLE.
REQ-021 Data path: registered mux, one-cycle latency; only EngineData/_en of ActiveMode forwarded, and only in RUN or DRAIN.
REQ-022 Forwarded word with UsbDataFifoFull = 1 in its input cycle is dropped (en not asserted); DropCount increments, saturates at 0xFFFF, and clears on the IDLE->RUN transition.
REQ-023 OutDac = UsbDac in IDLE or when ActiveMode = 0; otherwise the DacSelect slot carries EngineDac[ActiveMode] and the other slots carry UsbDac; registered, one-cycle latency.
REQ-024 OutScLoad = UsbScLoad in IDLE; in RUN/DRAIN = EngineScLoad[ActiveMode]; one-cycle registered pulse.
REQ-025 Watchdog: loads on each OutScLoad pulse and counts while MicrorocConfigDone = 0; cleared by MicrorocConfigDone = 1.
REQ-026 Watchdog reaching 2^TIMEOUT_W-1: ConfigTimeout one-cycle pulse; if in RUN, force transition to DRAIN.

Reset
REQ-027 reset = 1 at a rising Clk edge: state IDLE, all outputs 0, ActiveMode 0, DropCount 0, watchdog cleared, edge detectors primed with current StartStop = 0.
REQ-028 Reset mid-RUN/DRAIN: EngineStart and OutUsbStartStop 0 on the first edge; no SweepTestDone pulse.

Structure
REQ-029 Shared package holds the FSM state enum, default width constants, and the DropCount width.
REQ-030 One sub-module usb_data_mux: registered per-engine select, full-drop gating, saturating DropCount.

Verification
REQ-031 ModeSelect=1, StartStop 0->1, EngineDone[1] pulse at cycle 50, DataTransmitDone at cycle 60 -> EngineStart=3'b010 cycles 2..50, SweepTestDone single pulse at cycle 61, Busy 0 afterwards.
REQ-032 RUN mode 2, EngineData_en[2] for 8 words 0x0000..0x0007, UsbDataFifoFull high on words 3,4 -> 6 words out one cycle late, DropCount=2; concurrent EngineData_en[1] traffic is never forwarded.
REQ-033 ActiveMode=1, DacSelect=2, EngineDac[1]=10'h155, UsbDac all 10'h0AA -> OutDac = {10'h155,10'h0AA,10'h0AA}; after return to IDLE, all slots 10'h0AA.
REQ-034 TIMEOUT_W=4, EngineScLoad pulse, MicrorocConfigDone held 0 -> ConfigTimeout pulse 15 cycles later, FSM enters DRAIN.
REQ-035 reset asserted mid-RUN, ModeSelect=3 (out of range) then StartStop 0->1 -> outputs 0, FSM remains IDLE.

Source files
------------

// File: rtl/test_mode_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_mode_controller_pkg
// Description : Shared types and constants for the test mode controller:
//               FSM state encoding, default widths, DropCount width and a
//               helper that sizes select fields (never narrower than 1 bit).
// Revision    : 1.0 - initial release
// ============================================================================
package test_mode_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tmc_state_e;

    localparam int c_NUM_ENGINES_DEF = 3;
    localparam int c_DATA_W_DEF      = 16;
    localparam int c_DAC_W_DEF       = 10;
    localparam int c_NUM_DAC_DEF     = 3;
    localparam int c_TIMEOUT_W_DEF   = 24;
    localparam int c_DROP_CNT_W      = 16;

    // Width of an index selecting one of n items; a single item still gets
    // a 1-bit field so ports never collapse to zero width.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_data_mux.sv
`default_nettype none
// ============================================================================
// Module      : usb_data_mux
// Description : Registered per-engine data select toward the USB external
//               FIFO. Words arriving while the FIFO is full are dropped and
//               counted in a saturating drop counter.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_sel           - engine index to forward
//               i_fwd_en        - forwarding window (controller RUN/DRAIN)
//               i_drop_clr      - clears the drop counter
//               i_data/i_data_en- packed engine words and their valids
//               i_fifo_full     - FIFO full flag in the word's input cycle
//               o_data/o_data_en- forwarded word, one cycle latency
//               o_drop_cnt      - saturating count of dropped words
// Revision    : 1.0 - initial release
// ============================================================================
module usb_data_mux #(
    parameter int NUM_ENGINES = 3,
    parameter int DATA_W      = 16,
    parameter int SEL_W       = 2,
    parameter int DROP_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEL_W-1:0]              i_sel,
    input  logic                          i_fwd_en,
    input  logic                          i_drop_clr,
    input  logic [NUM_ENGINES*DATA_W-1:0] i_data,
    input  logic [NUM_ENGINES-1:0]        i_data_en,
    input  logic                          i_fifo_full,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_data_en,
    output logic [DROP_W-1:0]             o_drop_cnt
);

    logic [DATA_W-1:0] r_data_q,    w_data_d;
    logic              r_data_en_q, w_data_en_d;
    logic [DROP_W-1:0] r_drop_q,    w_drop_d;
    logic              w_sel_valid;

    always_comb begin
        w_sel_valid = i_fwd_en & i_data_en[i_sel];
        w_data_d    = i_data[int'(i_sel)*DATA_W +: DATA_W];
        w_data_en_d = w_sel_valid & ~i_fifo_full;
        w_drop_d    = r_drop_q;
        if (i_drop_clr) begin
            w_drop_d = '0;
        end else if (w_sel_valid && i_fifo_full && (r_drop_q != '1)) begin
            w_drop_d = r_drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q    <= '0;
            r_data_en_q <= 1'b0;
            r_drop_q    <= '0;
        end else begin
            r_data_q    <= w_data_d;
            r_data_en_q <= w_data_en_d;
            r_drop_q    <= w_drop_d;
        end
    end

    assign o_data     = r_data_q;
    assign o_data_en  = r_data_en_q;
    assign o_drop_cnt = r_drop_q;

endmodule
`default_nettype wire

// File: rtl/test_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : test_mode_controller
// Description : Selects one of NUM_ENGINES test engines (0 = normal ACQ,
//               others sweep-type), sequences start/drain/done, routes the
//               engine's data, DAC values and SC-load pulses, and watches the
//               Microroc configuration handshake with a timeout counter.
// Ports       : Clk, reset            - clock, synchronous active-high reset
//               ModeSelect, StartStop - requested engine, USB start level
//               EngineStart/Done      - one-hot start level, done pulses
//               EngineDac, UsbDac, DacSelect, OutDac - threshold DAC routing
//               EngineScLoad, UsbScLoad, OutScLoad, MicrorocConfigDone
//               EngineData(_en), UsbDataFifoFull, OutUsbExtFifoData(_en)
//               OutUsbStartStop, DataTransmitDone, SweepTestDone
//               ConfigTimeout, Busy, ActiveMode, DropCount
// Revision    : 1.0 - initial release
// ============================================================================
module test_mode_controller
    import test_mode_controller_pkg::*;
#(
    parameter  int NUM_ENGINES = c_NUM_ENGINES_DEF,
    parameter  int DATA_W      = c_DATA_W_DEF,
    parameter  int DAC_W       = c_DAC_W_DEF,
    parameter  int NUM_DAC     = c_NUM_DAC_DEF,
    parameter  int TIMEOUT_W   = c_TIMEOUT_W_DEF,
    localparam int MODE_W      = sel_width(NUM_ENGINES),
    localparam int DSEL_W      = sel_width(NUM_DAC)
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic [MODE_W-1:0]             ModeSelect,
    input  logic                          StartStop,
    output logic [NUM_ENGINES-1:0]        EngineStart,
    input  logic [NUM_ENGINES-1:0]        EngineDone,
    input  logic [NUM_ENGINES*DAC_W-1:0]  EngineDac,
    input  logic [NUM_ENGINES-1:0]        EngineScLoad,
    input  logic [NUM_DAC*DAC_W-1:0]      UsbDac,
    input  logic [DSEL_W-1:0]             DacSelect,
    output logic [NUM_DAC*DAC_W-1:0]      OutDac,
    input  logic                          UsbScLoad,
    output logic                          OutScLoad,
    input  logic                          MicrorocConfigDone,
    input  logic [NUM_ENGINES*DATA_W-1:0] EngineData,
    input  logic [NUM_ENGINES-1:0]        EngineData_en,
    input  logic                          UsbDataFifoFull,
    output logic [DATA_W-1:0]             OutUsbExtFifoData,
    output logic                          OutUsbExtFifoData_en,
    output logic                          OutUsbStartStop,
    input  logic                          DataTransmitDone,
    output logic                          SweepTestDone,
    output logic                          ConfigTimeout,
    output logic                          Busy,
    output logic [MODE_W-1:0]             ActiveMode,
    output logic [c_DROP_CNT_W-1:0]       DropCount
);

    localparam logic [TIMEOUT_W-1:0] c_WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    tmc_state_e                r_state_q, w_state_d;
    logic [MODE_W-1:0]         r_active_q, w_active_d;
    logic                      r_start_stop_q;
    logic                      w_rise, w_fall, w_run_entry, w_engine_window;
    logic [NUM_ENGINES-1:0]    w_engine_start;
    logic                      w_dac_override;
    logic [DAC_W-1:0]          w_engine_dac;
    logic [NUM_DAC*DAC_W-1:0]  r_out_dac_q, w_out_dac_d;
    logic                      r_sc_load_q, w_sc_load_d;
    logic [TIMEOUT_W-1:0]      r_wd_cnt_q, w_wd_cnt_d;
    logic                      r_wd_armed_q, w_wd_armed_d;
    logic                      r_timeout_q, w_timeout_d;

    assign w_rise = StartStop & ~r_start_stop_q;
    assign w_fall = ~StartStop & r_start_stop_q;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_d   = r_state_q;
        w_active_d  = r_active_q;
        w_run_entry = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_rise && (int'(ModeSelect) < NUM_ENGINES)) begin
                    w_active_d  = ModeSelect;
                    w_state_d   = ST_RUN;
                    w_run_entry = 1'b1;
                end
            end
            ST_RUN: begin
                // Done, stop request and config timeout all collapse into one exit.
                if (EngineDone[r_active_q] || w_fall || r_timeout_q) begin
                    w_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (DataTransmitDone) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_active_q     <= '0;
            r_start_stop_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_active_q     <= w_active_d;
            r_start_stop_q <= StartStop;
        end
    end

    always_comb begin
        w_engine_start = '0;
        if (r_state_q == ST_RUN) begin
            w_engine_start[r_active_q] = 1'b1;
        end
    end

    assign w_engine_window = (r_state_q == ST_RUN) || (r_state_q == ST_DRAIN);
    assign EngineStart     = w_engine_start;
    assign OutUsbStartStop = w_engine_window;
    assign SweepTestDone   = (r_state_q == ST_DONE);
    assign Busy            = (r_state_q != ST_IDLE);
    assign ActiveMode      = r_active_q;

    // ------------------------------------------------------------ data path
    usb_data_mux #(
        .NUM_ENGINES (NUM_ENGINES),
        .DATA_W      (DATA_W),
        .SEL_W       (MODE_W),
        .DROP_W      (c_DROP_CNT_W)
    ) u_usb_data_mux (
        .clk         (Clk),
        .rst         (reset),
        .i_sel       (r_active_q),
        .i_fwd_en    (w_engine_window),
        .i_drop_clr  (w_run_entry),
        .i_data      (EngineData),
        .i_data_en   (EngineData_en),
        .i_fifo_full (UsbDataFifoFull),
        .o_data      (OutUsbExtFifoData),
        .o_data_en   (OutUsbExtFifoData_en),
        .o_drop_cnt  (DropCount)
    );

    // ------------------------------------------------------------ DAC route
    // Normal ACQ (engine 0) never owns a DAC slot; sweep engines own the
    // selected slot for the whole run, including the DONE cycle.
    assign w_dac_override = (r_state_q != ST_IDLE) && (r_active_q != '0);
    assign w_engine_dac   = EngineDac[int'(r_active_q)*DAC_W +: DAC_W];

    for (genvar s = 0; s < NUM_DAC; s++) begin : g_dac_slot
        assign w_out_dac_d[s*DAC_W +: DAC_W] =
            (w_dac_override && (int'(DacSelect) == s)) ? w_engine_dac
                                                       : UsbDac[s*DAC_W +: DAC_W];
    end

    // ------------------------------------------------ SC load and watchdog
    always_comb begin
        w_sc_load_d = 1'b0;
        if (r_state_q == ST_IDLE) begin
            w_sc_load_d = UsbScLoad;
        end else if (w_engine_window) begin
            w_sc_load_d = EngineScLoad[r_active_q];
        end
    end

    // The watchdog loads on the same edge that raises OutScLoad, so the
    // timeout pulse lands 2^TIMEOUT_W-1 cycles after the SC load pulse.
    always_comb begin
        w_wd_cnt_d   = r_wd_cnt_q;
        w_wd_armed_d = r_wd_armed_q;
        w_timeout_d  = 1'b0;
        if (w_sc_load_d) begin
            w_wd_cnt_d   = '0;
            w_wd_armed_d = 1'b1;
        end else if (MicrorocConfigDone) begin
            w_wd_cnt_d   = '0;
            w_wd_armed_d = 1'b0;
        end else if (r_wd_armed_q) begin
            w_wd_cnt_d = r_wd_cnt_q + 1'b1;
            if (r_wd_cnt_q == c_WD_LAST) begin
                w_timeout_d  = 1'b1;
                w_wd_armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_out_dac_q  <= '0;
            r_sc_load_q  <= 1'b0;
            r_wd_cnt_q   <= '0;
            r_wd_armed_q <= 1'b0;
            r_timeout_q  <= 1'b0;
        end else begin
            r_out_dac_q  <= w_out_dac_d;
            r_sc_load_q  <= w_sc_load_d;
            r_wd_cnt_q   <= w_wd_cnt_d;
            r_wd_armed_q <= w_wd_armed_d;
            r_timeout_q  <= w_timeout_d;
        end
    end

    assign OutDac        = r_out_dac_q;
    assign OutScLoad     = r_sc_load_q;
    assign ConfigTimeout = r_timeout_q;

endmodule
`default_nettype wire
